spread_frame_ctrl: RTL and testbench

Frame sequencer placed in front of the Spread (DSSS chip spreader) block.
- Builds one burst per i_start: fixed preamble, length header, payload bits from a byte stream, then a silent guard gap.
- Feeds bits to the spreader over a valid/ready bit handshake and owns the spreader's enable line.
- Sole master of the spreader; upstream logic only supplies bytes and start commands.

---
 rtl/spread_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spread_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spread_frame_ctrl.sv
// Frame sequencer feeding a DSSS spreader: preamble, length header, payload bytes, guard gap.
// Define SPREAD_FRAME_CRC_EN to append a CRC-8 (poly 0x07) over header and payload bits.
module spread_frame_ctrl #(
   parameter int                      PREAMBLE_LEN  = 16,
   parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_WORD = 16'hA5A5,
   parameter int                      LEN_W         = 8,
   parameter int                      GAP_CYCLES    = 48
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic [7:0]       i_byte,
   input  logic             i_byte_valid,
   output logic             o_byte_ready,
   output logic             o_bit,
   output logic             o_bit_valid,
   input  logic             i_bit_ready,
   output logic             o_spread_enable,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_underrun
);
   localparam int SR_W0   = (PREAMBLE_LEN > LEN_W) ? PREAMBLE_LEN : LEN_W;
   localparam int SR_W    = (SR_W0 > 8) ? SR_W0 : 8;
   localparam int CNT_MAX = (SR_W > GAP_CYCLES) ? SR_W : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_CRC, S_GAP
   } state_t;

`ifdef SPREAD_FRAME_CRC_EN
   localparam state_t TAIL_STATE = S_CRC;
`else
   localparam state_t TAIL_STATE = S_GAP;
`endif

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [SR_W-1:0]  tx_sr_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] bytes_fetched_reg;
   logic [LEN_W-1:0] bytes_done_reg;
   logic [7:0]       byte_sr_reg;
   logic             byte_full_reg;
   logic [2:0]       byte_bits_reg;
   logic             underrun_reg;

   logic bit_valid, bit_out, spread_en, byte_ready, done;
   logic bit_xfer, byte_xfer, start_acc, payload_last;

`ifdef SPREAD_FRAME_CRC_EN
   logic [7:0] crc_reg;
   logic [7:0] crc_next;
   logic       crc_fb;

   always_comb begin
      crc_fb   = crc_reg[7] ^ bit_out;
      crc_next = {crc_reg[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
   end
`endif

   always_comb begin
      state_next   = state_reg;
      bit_valid    = 1'b0;
      bit_out      = 1'b0;
      spread_en    = 1'b0;
      byte_ready   = 1'b0;
      done         = 1'b0;
      start_acc    = 1'b0;
      payload_last = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (i_start) begin
               start_acc  = 1'b1;
               state_next = S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            spread_en = 1'b1;
            bit_valid = 1'b1;
            bit_out   = tx_sr_reg[SR_W-1];
            if (i_bit_ready && cnt_reg == CNT_W'(PREAMBLE_LEN - 1))
               state_next = S_HEADER;
         end
         S_HEADER: begin
            spread_en  = 1'b1;
            bit_valid  = 1'b1;
            bit_out    = tx_sr_reg[SR_W-1];
            byte_ready = !byte_full_reg && (bytes_fetched_reg < len_reg);
            if (i_bit_ready && cnt_reg == CNT_W'(LEN_W - 1))
               state_next = (len_reg == '0) ? TAIL_STATE : S_PAYLOAD;
         end
         S_PAYLOAD: begin
            // An empty register simply withholds valid; the enable stays up through starvation.
            spread_en    = 1'b1;
            bit_valid    = byte_full_reg;
            bit_out      = byte_full_reg & byte_sr_reg[7];
            byte_ready   = !byte_full_reg && (bytes_fetched_reg < len_reg);
            payload_last = byte_full_reg && i_bit_ready && (byte_bits_reg == 3'd7) &&
                           (bytes_done_reg == len_reg - LEN_W'(1));
            if (payload_last)
               state_next = TAIL_STATE;
         end
`ifdef SPREAD_FRAME_CRC_EN
         S_CRC: begin
            spread_en = 1'b1;
            bit_valid = 1'b1;
            bit_out   = tx_sr_reg[SR_W-1];
            if (i_bit_ready && cnt_reg == CNT_W'(7))
               state_next = S_GAP;
         end
`endif
         S_GAP: begin
            if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
               done       = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
      bit_xfer  = bit_valid && i_bit_ready;
      byte_xfer = byte_ready && i_byte_valid;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_reg           <= '0;
         tx_sr_reg         <= '0;
         len_reg           <= '0;
         bytes_fetched_reg <= '0;
         bytes_done_reg    <= '0;
         byte_sr_reg       <= '0;
         byte_full_reg     <= 1'b0;
         byte_bits_reg     <= '0;
         underrun_reg      <= 1'b0;
      end else begin
         if (state_next != state_reg)
            cnt_reg <= '0;
         else if (state_reg == S_GAP || bit_xfer)
            cnt_reg <= cnt_reg + CNT_W'(1);

         // Fixed fields go out from one MSB-aligned shift register, reloaded at each field boundary.
         if (start_acc)
            tx_sr_reg <= SR_W'(PREAMBLE_WORD) << (SR_W - PREAMBLE_LEN);
         else if (state_reg == S_PREAMBLE && state_next == S_HEADER)
            tx_sr_reg <= SR_W'(len_reg) << (SR_W - LEN_W);
`ifdef SPREAD_FRAME_CRC_EN
         else if (state_next == S_CRC && state_reg != S_CRC)
            tx_sr_reg <= SR_W'(crc_next) << (SR_W - 8);
`endif
         else if (bit_xfer)
            tx_sr_reg <= {tx_sr_reg[SR_W-2:0], 1'b0};

         if (start_acc) begin
            len_reg           <= i_len;
            bytes_fetched_reg <= '0;
            bytes_done_reg    <= '0;
         end

         if (start_acc)
            underrun_reg <= 1'b0;
         else if (state_reg == S_PAYLOAD && !byte_full_reg && i_bit_ready)
            underrun_reg <= 1'b1;

         // Ready requires an empty register, so a load never coincides with a payload shift.
         if (byte_xfer) begin
            byte_sr_reg       <= i_byte;
            byte_full_reg     <= 1'b1;
            byte_bits_reg     <= '0;
            bytes_fetched_reg <= bytes_fetched_reg + LEN_W'(1);
         end else if (state_reg == S_PAYLOAD && bit_xfer) begin
            byte_sr_reg   <= {byte_sr_reg[6:0], 1'b0};
            byte_bits_reg <= byte_bits_reg + 3'd1;
            if (byte_bits_reg == 3'd7) begin
               byte_full_reg  <= 1'b0;
               bytes_done_reg <= bytes_done_reg + LEN_W'(1);
            end
         end
      end
   end

`ifdef SPREAD_FRAME_CRC_EN
   always_ff @(posedge i_clk) begin
      if (i_reset)
         crc_reg <= '0;
      else if (start_acc)
         crc_reg <= '0;
      else if (bit_xfer && (state_reg == S_HEADER || state_reg == S_PAYLOAD))
         crc_reg <= crc_next;
   end
`endif

   assign o_bit           = bit_out;
   assign o_bit_valid     = bit_valid;
   assign o_spread_enable = spread_en;
   assign o_byte_ready    = byte_ready;
   assign o_busy          = (state_reg != S_IDLE);
   assign o_done          = done;
   assign o_underrun      = underrun_reg;

endmodule

// File: tb/tb_spread_frame_ctrl.sv
// Scoreboard bench for spread_frame_ctrl with a behavioural spreader (24 cycles per bit).
module tb_spread_frame_ctrl;
   localparam int          PREAMBLE_LEN  = 16;
   localparam logic [15:0] PREAMBLE_WORD = 16'hA5A5;
   localparam int          LEN_W         = 8;
   localparam int          GAP_CYCLES    = 48;
   localparam int          SPREAD        = 24;
   localparam int          BUDGET        = 20000;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] len_in, byte_d;
   logic       byte_valid, byte_ready;
   logic       dbit, bit_valid, bit_ready;
   logic       spread_en, busy, done, underrun;

   always #5 clk = ~clk;

   spread_frame_ctrl #(
      .PREAMBLE_LEN (PREAMBLE_LEN),
      .PREAMBLE_WORD(PREAMBLE_WORD),
      .LEN_W        (LEN_W),
      .GAP_CYCLES   (GAP_CYCLES)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_start        (start),
      .i_len          (len_in),
      .i_byte         (byte_d),
      .i_byte_valid   (byte_valid),
      .o_byte_ready   (byte_ready),
      .o_bit          (dbit),
      .o_bit_valid    (bit_valid),
      .i_bit_ready    (bit_ready),
      .o_spread_enable(spread_en),
      .o_busy         (busy),
      .o_done         (done),
      .o_underrun     (underrun)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic       exp_bits[$];
   logic       exp_under[$];
   logic [7:0] byte_q[$];
   logic       byte_hold = 1'b0;
   int         xfer_total = 0;
   int         ready_seen = 0;
   int         gap_cnt = 0;
   int         spr_busy = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Spreader: ready when enabled and idle; each accepted bit occupies it for SPREAD cycles.
   always @(posedge clk) begin
      if (rst || !spread_en)          spr_busy <= 0;
      else if (bit_valid && bit_ready) spr_busy <= SPREAD - 1;
      else if (spr_busy > 0)           spr_busy <= spr_busy - 1;
   end
   assign bit_ready = spread_en && (spr_busy == 0);

   // Byte source: presents the head of byte_q unless held.
   initial begin
      logic took;
      byte_valid = 1'b0;
      byte_d     = 8'h00;
      forever begin
         @(negedge clk);
         took = byte_valid && byte_ready;
         @(posedge clk);
         #1;
         if (took && byte_q.size() > 0) void'(byte_q.pop_front());
         byte_valid = (byte_q.size() > 0) && !byte_hold;
         byte_d     = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
      end
   end

   // Monitor: pops expected bits on every transfer, checks gap length and done/underrun.
   logic prev_valid = 1'b0, prev_bit = 1'b0, prev_xfer = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         gap_cnt    = 0;
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_xfer) begin
            check1("bit_valid_hold", bit_valid, 1'b1);
            check1("bit_value_hold", dbit, prev_bit);
         end
         if (bit_valid) check1("enable_with_valid", spread_en, 1'b1);
         if (byte_ready) ready_seen++;
         if (bit_valid && bit_ready) begin
            xfer_total++;
            if (exp_bits.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_bit: got bit %b, required no transfer", dbit);
            end else begin
               check1("bit", dbit, exp_bits.pop_front());
            end
         end
         if (busy && !spread_en) gap_cnt++;
         else gap_cnt = 0;
         if (done) begin
            checki("gap_len", gap_cnt, GAP_CYCLES);
            checki("bits_left_at_done", exp_bits.size(), 0);
            if (exp_under.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got o_done=1, required 0");
            end else begin
               check1("underrun_at_done", underrun, exp_under.pop_front());
            end
         end
         prev_valid = bit_valid;
         prev_bit   = dbit;
         prev_xfer  = bit_valid && bit_ready;
      end
   end

   // Reference frame built from the field rules; caller is at #1 after a posedge with DUT idle.
   task automatic start_frame(input logic [7:0] l, input logic [7:0] data[8], input logic exp_u);
      logic [7:0] crc;
      logic       fb;
      logic       b;
      crc = 8'h00;
      for (int i = PREAMBLE_LEN - 1; i >= 0; i--) exp_bits.push_back(PREAMBLE_WORD[i]);
      for (int i = LEN_W - 1; i >= 0; i--) begin
         b  = l[i];
         exp_bits.push_back(b);
         fb = crc[7] ^ b;
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      for (int k = 0; k < int'(l); k++) begin
         byte_q.push_back(data[k]);
         for (int j = 7; j >= 0; j--) begin
            b  = data[k][j];
            exp_bits.push_back(b);
            fb = crc[7] ^ b;
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
`ifdef SPREAD_FRAME_CRC_EN
      for (int j = 7; j >= 0; j--) exp_bits.push_back(crc[j]);
`endif
      exp_under.push_back(exp_u);
      $display("frame start: len=%0d bytes=%0d expected_bits=%0d", l, l, exp_bits.size());
      start  = 1'b1;
      len_in = l;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < BUDGET) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_idle: got busy=1 after %0d cycles, required 0", BUDGET);
      end
   endtask

   task automatic wait_xfers(input int target);
      int n = 0;
      while (xfer_total < target && n < BUDGET) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (xfer_total < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_xfer: got %0d transfers, required %0d", xfer_total, target);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_bit"}, dbit, 1'b0);
      check1({tag, "_bit_valid"}, bit_valid, 1'b0);
      check1({tag, "_byte_ready"}, byte_ready, 1'b0);
      check1({tag, "_spread_enable"}, spread_en, 1'b0);
      check1({tag, "_busy"}, busy, 1'b0);
      check1({tag, "_done"}, done, 1'b0);
      check1({tag, "_underrun"}, underrun, 1'b0);
   endtask

   initial begin
      logic [7:0] data[8];
      int         base, rs, n;
      rst    = 1'b1;
      start  = 1'b0;
      len_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Abort mid-preamble; start during reset must lose.
      data = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      base = xfer_total;
      start_frame(8'd1, data, 1'b0);
      wait_xfers(base + 5);
      rst = 1'b1;
      exp_bits.delete();
      exp_under.delete();
      byte_q.delete();
      @(posedge clk);
      #1;
      check_all_zero("abort");
      start  = 1'b1;
      len_in = 8'd3;
      @(posedge clk);
      #1;
      check1("start_during_reset_busy", busy, 1'b0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      data = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(8'd1, data, 1'b0);
      check1("busy_after_start", busy, 1'b1);
      wait_idle();

      // len=2 payload
      data = '{8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(8'd2, data, 1'b0);
      wait_idle();

      // len=0: byte ready must never rise
      n = ready_seen;
      start_frame(8'd0, data, 1'b0);
      wait_idle();
      checki("len0_byte_ready_cycles", ready_seen - n, 0);

      // Starvation: byte withheld after header
      byte_hold = 1'b1;
      base = xfer_total;
      data = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(8'd1, data, 1'b1);
      wait_xfers(base + PREAMBLE_LEN + LEN_W);
      repeat (100) @(posedge clk);
      #1;
      check1("starve_bit_valid", bit_valid, 1'b0);
      check1("starve_spread_enable", spread_en, 1'b1);
      check1("starve_underrun", underrun, 1'b1);
      byte_hold = 1'b0;
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check1("underrun_sticky_idle", underrun, 1'b1);

      // Starts during payload and in the done cycle are ignored
      base = xfer_total;
      data = '{8'h81, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(8'd2, data, 1'b0);
      check1("underrun_cleared_on_start", underrun, 1'b0);
      wait_xfers(base + 30);
      start  = 1'b1;
      len_in = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      @(negedge clk);
      while (!done && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_done: got o_done=0, required 1");
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check1("start_in_done_ignored", busy, 1'b0);

      // Single byte 0x01 (CRC 0x12 when the CRC trailer is built in)
      data = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(8'd1, data, 1'b0);
      wait_idle();

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 8; k++) data[k] = 8'($urandom_range(0, 255));
         rs = $urandom_range(0, 10);
         repeat (rs) @(posedge clk);
         #1;
         start_frame(8'($urandom_range(0, 5)), data, 1'b0);
         wait_idle();
      end

      repeat (5) @(posedge clk);
      #1;
      checki("bits_remaining", exp_bits.size(), 0);
      checki("done_remaining", exp_under.size(), 0);
      checki("bytes_remaining", byte_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
